// File: rtl/f_pool_pkg.sv
// rtl/f_pool_pkg.sv - shared state encoding and default widths for the max unpool block
package f_pool_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int DELAY_W_DEF = 7;

    typedef enum logic {
        ST_EXPAND = 1'b0,
        ST_WAIT   = 1'b1
    } pool_state_e;

endpackage

// File: rtl/f_window_counter.sv
// rtl/f_window_counter.sv - start delay countdown and window position counter
module f_window_counter
    import f_pool_pkg::*;
#(
    parameter int DELAY_W = DELAY_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               running,
    input  logic [DELAY_W-1:0] stride_minus_one,
    input  logic [DELAY_W-1:0] delay0,
    output pool_state_e        state,
    output logic [DELAY_W-1:0] position,
    output logic               win_start
);

    pool_state_e        state_q, state_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [DELAY_W-1:0] pos_q, pos_d;

    // Next state: run restarts the countdown, otherwise advance only while running.
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        pos_d   = pos_q;
        if (run) begin
            state_d = ST_WAIT;
            delay_d = delay0;
            pos_d   = '0;
        end else if (running) begin
            case (state_q)
                ST_WAIT: begin
                    if (delay_q == '0) begin
                        state_d = ST_EXPAND;
                    end else begin
                        delay_d = delay_q - 1'b1;
                    end
                end
                default: begin
                    // >= rather than == so a stride shrunk mid-window still wraps.
                    if (pos_q >= stride_minus_one) begin
                        pos_d = '0;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EXPAND;
            delay_q <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            pos_q   <= pos_d;
        end
    end

    assign state     = state_q;
    assign position  = pos_q;
    assign win_start = !run && running && (state_q == ST_EXPAND) && (pos_q == '0);

endmodule

// File: rtl/f_max_unpool.sv
// rtl/f_max_unpool.sv - max unpool expander; MAX_UNPOOL_INDEX_EN selects sparse argmax mode, else broadcast
module f_max_unpool
    import f_pool_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DELAY_W = DELAY_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               running,
    input  logic [DELAY_W-1:0] strideMinusOne,
    input  logic [DELAY_W-1:0] delay0,
    input  logic [DATA_W-1:0]  in0,
    input  logic [DELAY_W-1:0] in1,
    output logic [DATA_W-1:0]  out0,
    output logic [DELAY_W-1:0] out1
);

    pool_state_e        state;
    logic [DELAY_W-1:0] position;
    logic               win_start;

    f_window_counter #(
        .DELAY_W(DELAY_W)
    ) u_window_counter (
        .clk              (clk),
        .rst_n            (rst),
        .run              (run),
        .running          (running),
        .stride_minus_one (strideMinusOne),
        .delay0           (delay0),
        .state            (state),
        .position         (position),
        .win_start        (win_start)
    );

    logic [DATA_W-1:0]  held_val_q, held_val_d;
    logic [DATA_W-1:0]  out0_q, out0_d;
    logic [DELAY_W-1:0] out1_q, out1_d;
    logic [DATA_W-1:0]  cur_val;
    logic               sel;

`ifdef MAX_UNPOOL_INDEX_EN
    logic [DELAY_W-1:0] held_idx_q, held_idx_d;
    logic [DELAY_W-1:0] cur_idx;
`else
    logic               unused_in1;
    assign unused_in1 = ^in1;
`endif

    // Window start bypasses the held registers so the first output uses live inputs.
    always_comb begin
        cur_val = win_start ? in0 : held_val_q;
`ifdef MAX_UNPOOL_INDEX_EN
        cur_idx = win_start ? in1 : held_idx_q;
        sel     = (cur_idx == position);
`else
        sel     = 1'b1;
`endif
    end

    // Output and capture next values; run clears the outputs, running low holds everything.
    always_comb begin
        out0_d     = out0_q;
        out1_d     = out1_q;
        held_val_d = held_val_q;
`ifdef MAX_UNPOOL_INDEX_EN
        held_idx_d = held_idx_q;
`endif
        if (run) begin
            out0_d = '0;
            out1_d = '0;
        end else if (running) begin
            if (state == ST_WAIT) begin
                out0_d = '0;
                out1_d = '0;
            end else begin
                out0_d = sel ? cur_val : '0;
                out1_d = position;
                if (win_start) begin
                    held_val_d = in0;
`ifdef MAX_UNPOOL_INDEX_EN
                    held_idx_d = in1;
`endif
                end
            end
        end
    end

    // Held value/index and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_val_q <= '0;
            out0_q     <= '0;
            out1_q     <= '0;
`ifdef MAX_UNPOOL_INDEX_EN
            held_idx_q <= '0;
`endif
        end else begin
            held_val_q <= held_val_d;
            out0_q     <= out0_d;
            out1_q     <= out1_d;
`ifdef MAX_UNPOOL_INDEX_EN
            held_idx_q <= held_idx_d;
`endif
        end
    end

    assign out0 = out0_q;
    assign out1 = out1_q;

endmodule
